// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, data width and line levels shared by the UART transmitter and receiver.
// Defining UART_TX_PARITY_EN adds the PARITY state and the even-parity helper.
package uart_pkg;

    localparam int DATA_W = 8;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } uart_state_t;

`ifdef UART_TX_PARITY_EN
    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter running 0..CLKS_PER_BIT-1 with a terminal-count pulse
// on the last cycle of each bit and a synchronous restart that holds it at zero.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Restart,
    output logic o_Tc
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] r_Cnt;

    assign o_Tc = (r_Cnt == LAST);

    // Count cycles within the current bit; wrap on terminal count, clear while restarted.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Cnt <= '0;
        end else if (i_Restart || o_Tc) begin
            r_Cnt <= '0;
        end else begin
            r_Cnt <= r_Cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first, idle-high line, registered serial output.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between data bit 7 and the stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_TX_DV,
    input  logic [DATA_W-1:0] i_TX_Byte,
    output logic              o_TX_Serial,
    output logic              o_TX_Active,
    output logic              o_TX_Done
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    if (CLKS_PER_BIT < 2) begin : g_cpb_check
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end

    uart_state_t       r_State;
    logic [DATA_W-1:0] r_Byte;
    logic [IDX_W-1:0]  r_Idx;
    logic              r_Serial;
    logic              r_Active;
    logic              r_Done;
    logic              w_Tc;
    logic              w_Restart;

    // The bit timer is held at zero while idle so the start bit gets a full period.
    assign w_Restart = (r_State == S_IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Restart(w_Restart),
        .o_Tc     (w_Tc)
    );

    assign o_TX_Serial = r_Serial;
    assign o_TX_Active = r_Active;
    assign o_TX_Done   = r_Done;

    // Frame sequencer; every output is registered and set one bit ahead of its state.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State  <= S_IDLE;
            r_Byte   <= '0;
            r_Idx    <= '0;
            r_Serial <= LINE_IDLE;
            r_Active <= 1'b0;
            r_Done   <= 1'b0;
        end else begin
            r_Done <= 1'b0;
            case (r_State)
                S_IDLE: begin
                    r_Serial <= LINE_IDLE;
                    r_Active <= 1'b0;
                    r_Idx    <= '0;
                    if (i_TX_DV) begin
                        r_Byte   <= i_TX_Byte;
                        r_Serial <= LINE_START;
                        r_Active <= 1'b1;
                        r_State  <= S_START;
                    end
                end
                S_START: begin
                    if (w_Tc) begin
                        r_Serial <= r_Byte[0];
                        r_State  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_Tc) begin
                        if (r_Idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                            r_Serial <= even_parity(r_Byte);
                            r_State  <= S_PARITY;
`else
                            r_Serial <= LINE_STOP;
                            r_State  <= S_STOP;
`endif
                        end else begin
                            r_Idx    <= r_Idx + 1'b1;
                            r_Serial <= r_Byte[r_Idx + 1'b1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_Tc) begin
                        r_Serial <= LINE_STOP;
                        r_State  <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_Tc) begin
                        r_Serial <= LINE_IDLE;
                        r_Active <= 1'b0;
                        r_Done   <= 1'b1;
                        r_State  <= S_IDLE;
                    end
                end
                default: r_State <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with a frame-level reference model,
// a loopback receiver, and two instances (217 and 4 clocks per bit).
module tb_uart_tx;

    localparam int CPB0 = 217;
    localparam int CPB1 = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic dv [2];
    logic [7:0] tb_byte [2];
    logic ser [2];
    logic act [2];
    logic done [2];

    int n_chk = 0;
    int n_err = 0;
    logic seq [0:2600];
    logic [7:0] rx_q [$];

    bit m_act [2];
    bit m_done [2];
    int m_pos [2];
    logic [10:0] m_bits [2];

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB0)) dut0 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_TX_DV(dv[0]), .i_TX_Byte(tb_byte[0]),
        .o_TX_Serial(ser[0]), .o_TX_Active(act[0]), .o_TX_Done(done[0])
    );

    uart_tx #(.CLKS_PER_BIT(CPB1)) dut1 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_TX_DV(dv[1]), .i_TX_Byte(tb_byte[1]),
        .o_TX_Serial(ser[1]), .o_TX_Active(act[1]), .o_TX_Done(done[1])
    );

    function automatic void chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endfunction

    // Line levels of one frame, in transmission order.
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
        f[9] = ^b;
`endif
        return f;
    endfunction

    // Reference model: a frame occupies NB*cpb cycles after acceptance, Done follows it.
    initial forever begin
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            int cpb;
            cpb = (c == 0) ? CPB0 : CPB1;
            if (!rst_n) begin
                m_act[c] = 1'b0;
                m_done[c] = 1'b0;
            end else if (m_act[c]) begin
                m_pos[c]++;
                m_done[c] = (m_pos[c] == NB * cpb);
                if (m_done[c]) m_act[c] = 1'b0;
            end else begin
                m_done[c] = 1'b0;
                if (dv[c]) begin
                    m_act[c] = 1'b1;
                    m_pos[c] = 0;
                    m_bits[c] = frame_bits(tb_byte[c]);
                end
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    initial forever begin
        @(posedge clk);
        #2;
        for (int c = 0; c < 2; c++) begin
            int cpb;
            cpb = (c == 0) ? CPB0 : CPB1;
            chk(c == 0 ? "serial0" : "serial1", int'(ser[c]),
                m_act[c] ? int'(m_bits[c][m_pos[c] / cpb]) : 1);
            chk(c == 0 ? "active0" : "active1", int'(act[c]), int'(m_act[c]));
            chk(c == 0 ? "done0" : "done1", int'(done[c]), int'(m_done[c]));
        end
    end

    task automatic rx_step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Loopback receiver on instance 0: mid-bit sampling, parity bit skipped.
    initial forever begin
        logic [7:0] b;
        rx_step(1);
        if (rst_n && ser[0] == 1'b0) begin
            rx_step(CPB0 / 2);
            if (ser[0] == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    rx_step(CPB0);
                    b[i] = ser[0];
                end
                rx_step(CPB0 * (NB - 9));
                if (ser[0]) rx_q.push_back(b);
            end
        end
    end

    task automatic expect_rx(input string name, input logic [7:0] exp);
        int t = 0;
        while (rx_q.size() == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (rx_q.size() == 0) chk(name, -1, int'(exp));
        else chk(name, int'(rx_q.pop_front()), int'(exp));
    endtask

    // Sends one byte on instance 0 from a negedge; returns at the negedge of the Done cycle.
    task automatic run_frame(input logic [7:0] b, input bit inj, output int done_at, output int act_n);
        done_at = 0;
        act_n = 0;
        dv[0] = 1'b1;
        tb_byte[0] = b;
        for (int k = 1; k <= NB * CPB0 + 20 && done_at == 0; k++) begin
            @(negedge clk);
            dv[0] = inj && (k == 100 || k == 1000);
            tb_byte[0] = dv[0] ? 8'h00 : 8'($urandom);
            seq[k] = ser[0];
            if (act[0]) act_n++;
            if (done[0]) done_at = k;
        end
        if (done_at == 0) chk("frame_done_timeout", 0, 1);
    endtask

    task automatic chan0();
        int d, a, z, extra;
        int exp26 [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
        run_frame(8'h3F, 1'b0, d, a);
        chk("done_cycle_3F", d, NB * CPB0 + 1);
        chk("active_cycles_3F", a, NB * CPB0);
        z = 0;
        while (z < 2400 && seq[z+1] == 1'b0) z++;
        chk("start_low_run_3F", z, CPB0);
        for (int i = 0; i < 8; i++) chk("data_bit_3F", int'(seq[326 + CPB0 * i]), exp26[i]);
        chk("stop_high_3F", int'(seq[NB * CPB0]), 1);
        expect_rx("rx_3F", 8'h3F);
        run_frame(8'hA5, 1'b1, d, a);
        extra = 0;
        repeat (300) begin
            @(negedge clk);
            if (done[0]) extra++;
        end
        chk("ignored_dv_extra_done", extra, 0);
        expect_rx("rx_A5", 8'hA5);
        chk("ignored_dv_rx_count", rx_q.size(), 0);
        run_frame(8'h55, 1'b0, d, a);
        chk("done_line_high", int'(seq[d]), 1);
        run_frame(8'hAA, 1'b0, d, a);
        chk("b2b_start_next_cycle", int'(seq[1]), 0);
        expect_rx("rx_55", 8'h55);
        expect_rx("rx_AA", 8'hAA);
        dv[0] = 1'b1;
        tb_byte[0] = 8'h0F;
        for (int k = 1; k <= 1100; k++) begin
            @(negedge clk);
            dv[0] = 1'b0;
        end
        chk("bit4_low_0F", int'(ser[0]), 0);
        rst_n = 1'b0;
        #1;
        chk("reset_line_high", int'(ser[0]), 1);
        chk("reset_active_low", int'(act[0]), 0);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (done[0]) extra++;
        end
        rst_n = 1'b1;
        repeat (2400) begin
            @(negedge clk);
            if (done[0]) extra++;
        end
        chk("reset_no_done", extra, 0);
        rx_q.delete();
        run_frame(8'h81, 1'b0, d, a);
        chk("done_cycle_81", d, NB * CPB0 + 1);
        expect_rx("rx_81", 8'h81);
`ifdef UART_TX_PARITY_EN
        run_frame(8'h07, 1'b0, d, a);
        chk("parity_07", int'(seq[218 + 8 * CPB0 + 108]), 1);
        chk("parity_done_cycle", d, 11 * CPB0 + 1);
        expect_rx("rx_07", 8'h07);
        run_frame(8'h03, 1'b0, d, a);
        chk("parity_03", int'(seq[218 + 8 * CPB0 + 108]), 0);
        expect_rx("rx_03", 8'h03);
`endif
        for (int n = 0; n < 6; n++) begin
            logic [7:0] b;
            b = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_frame(b, 1'b0, d, a);
            expect_rx("rx_random", b);
        end
    endtask

    task automatic chan1();
        int low_n = 0, last_low = 0, done_at = 0, act_n = 0;
        dv[1] = 1'b1;
        tb_byte[1] = 8'hFF;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            dv[1] = 1'b0;
            if (!ser[1]) begin
                low_n++;
                last_low = k;
            end
            if (act[1]) act_n++;
            if (done[1] && done_at == 0) done_at = k;
        end
        chk("cpb4_low_cycles", low_n, 4);
        chk("cpb4_low_last", last_low, 4);
        chk("cpb4_active_cycles", act_n, NB * CPB1);
        chk("cpb4_done_cycle", done_at, NB * CPB1 + 1);
        repeat (8000) begin
            @(negedge clk);
            dv[1] = ($urandom_range(0, 3) == 0);
            tb_byte[1] = 8'($urandom);
        end
        dv[1] = 1'b0;
    endtask

    // Reset, directed and random scenarios on both instances, then the summary.
    initial begin
        dv[0] = 1'b0;
        dv[1] = 1'b0;
        tb_byte[0] = 8'h00;
        tb_byte[1] = 8'h00;
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_serial0", int'(ser[0]), 1);
        chk("reset_active0", int'(act[0]), 0);
        chk("reset_done0", int'(done[0]), 0);
        chk("reset_serial1", int'(ser[1]), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fork
            chan0();
            chan1();
        join
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
